reg_transfer_unit: RTL and testbench
====================================

# reg_transfer_unit

- Datapath end of the move protocol driven by the instruction sequencer.
- Holds the 16×16-bit register file and executes each sequencer move: copies a source value into a destination register.
- Sources are an ordinary register, the immediate operand (address 0xA) or the ALU result (address 0xD).
- Two-stage pipeline (capture, writeback) with forwarding, so back-to-back moves from the sequencer see each other's results.

## Interface
Parameters:
- DATA_W, 16, register and operand width
- OUT_ADDR, 4'hF, register whose writes are also presented on out_data

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- mov_enable  input  1  move request, sampled each rising edge
- reg_addr_from  input  4  source: 0xA = operand, 0xD = ALU, else register
- reg_addr_to  input  4  destination register
- operand  input  DATA_W  immediate data (source 0xA) or ALU opcode in [3:0] (source 0xD)
- out_data  output  DATA_W  last value written to OUT_ADDR
- out_valid  output  1  one-cycle pulse when out_data updates
- flags  output  3  {N, Z, C} from last ALU move
- dbg_addr  input  4  debug read address
- dbg_data  output  DATA_W  committed contents of regfile[dbg_addr], combinational

## Operation
- Capture stage (C), on an edge with mov_enable=1:
  - Latch wb_addr=reg_addr_to and wb_data=source value; set wb_valid=1, wb_alu=(from==0xD).
  - mov_enable=0 sets wb_valid=0.
- Source value:
  - 0xA: operand.
  - 0xD: ALU(op=operand[3:0]) with A=reg 0xB, B=reg 0xC.
  - Else: regfile[from].
- ALU ops:
  - 0 ADD: A+B, 17-bit, C=carry out.
  - 1 SUB: A−B, C=1 when A<B unsigned.
  - 2 AND, 3 OR, 4 XOR: C=0.
  - 5 NOT A: C=0.
  - 6–15: pass A, C=0.
  - Z=(result==0); N=result[15].
  - Results truncated to DATA_W.
- Writeback stage (W), on the edge after C, when wb_valid=1:
  - regfile[wb_addr] <= wb_data.
  - If wb_alu, flags <= captured {N,Z,C}.
  - If wb_addr==OUT_ADDR, out_data <= wb_data and out_valid=1 for that cycle.
- Forwarding: any register read in C (source, ALU A=0xB, ALU B=0xC) whose address equals a valid pending wb_addr uses wb_data instead of regfile.
- Moves to 0xA or 0xD write the physical register, but reading those addresses as a source always selects operand/ALU, never the stored value.
- Moves where from==to:
  - Register source: legal no-op write.
  - 0xA or 0xD source: writes the operand/ALU value.
- dbg_data reads committed regfile only; no forwarding.

## Timing
- Reset (rst_n=0 at edge):
  - All 16 registers = 0, wb_valid=0, flags=3'b000, out_data=0, out_valid=0.
  - Any pending writeback is dropped.
  - mov_enable is ignored during the reset edge.
- Latency: move sampled at edge n; regfile updated at edge n+1; visible on dbg_data after edge n+1.
- Throughput: one move per cycle, no stalls, no backpressure.
- Back-to-back: a move at edge n+1 reading the destination of the move at edge n gets the new value through forwarding.
- Simultaneous: a W write and a C read to the same address in one cycle resolve to the forwarded (new) value.
- out_valid is high exactly one cycle per write to OUT_ADDR; consecutive writes give consecutive pulses.

## Configuration
- REG_TRANSFER_FLAGS_EN defined:
  - flags register and N/Z/C logic present, as above.
- Undefined:
  - No flags state; flags output tied to 3'b000.
  - ALU results unchanged.

## Test plan
- Reset, then immediate load: mov from=0xA to=0x1 operand=0x1234 -> dbg_addr=1 shows 0x1234 after one further edge; all other registers 0.
- Forwarding: back-to-back (A→1, 0x00FF) then (1→2) -> reg2=0x00FF one edge after the second move.
- ALU add with carry: reg B=0xFFFF, reg C=0x0001, mov from=0xD to=0x3 op=0 -> reg3=0x0000, flags={N0,Z1,C1}.
- ALU sub borrow: B=0x0002, C=0x0005, op=1 -> result 0xFFFD, flags={1,0,1}; op=4 with B=C -> 0, flags={0,1,0}.
- Output port: two consecutive moves to 0xF (0xAAAA, 0x5555) -> out_valid high two consecutive cycles, out_data 0xAAAA then 0x5555.
- Reset mid-operation: assert rst_n=0 on the edge after a move to reg 4 -> reg4 stays 0, out_valid 0, flags 0.

Source files
------------

// File: rtl/reg_transfer_unit.sv
// reg_transfer_unit: 16-entry register file executing sequencer moves through a
// capture/writeback pipeline with forwarding. Define REG_TRANSFER_FLAGS_EN for N/Z/C flags.
module reg_transfer_unit #(
  parameter int         DATA_W   = 16,
  parameter logic [3:0] OUT_ADDR = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mov_enable,
  input  logic [3:0]        reg_addr_from,
  input  logic [3:0]        reg_addr_to,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [2:0]        flags,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] SRC_IMM = 4'hA;
  localparam logic [3:0] SRC_ALU = 4'hD;
  localparam logic [3:0] ALU_A   = 4'hB;
  localparam logic [3:0] ALU_B   = 4'hC;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;

  logic [DATA_W-1:0] regs_q [16];

  logic              wb_valid_q;
  logic [3:0]        wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] wb_data_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_hit;

  logic [DATA_W-1:0] rd_view [16];
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   alu_wide;
  logic [DATA_W-1:0] alu_res;

  // Capture-stage view of the register file: a pending writeback overrides the stored value.
  for (genvar gi = 0; gi < 16; gi++) begin : g_fwd
    assign rd_view[gi] = (wb_valid_q && (wb_addr_q == 4'(gi))) ? wb_data_q : regs_q[gi];
  end

  assign alu_a = rd_view[ALU_A];
  assign alu_b = rd_view[ALU_B];

  // Bit DATA_W of alu_wide is the carry for ADD and the borrow (A<B) for SUB, zero otherwise.
  always_comb begin
    alu_wide = '0;
    unique case (operand[3:0])
      OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
      OP_OR:   alu_wide = {1'b0, alu_a | alu_b};
      OP_XOR:  alu_wide = {1'b0, alu_a ^ alu_b};
      OP_NOT:  alu_wide = {1'b0, ~alu_a};
      default: alu_wide = {1'b0, alu_a};
    endcase
  end

  assign alu_res = alu_wide[DATA_W-1:0];

  always_comb begin
    wb_data_d = rd_view[reg_addr_from];
    if (reg_addr_from == SRC_IMM) begin
      wb_data_d = operand;
    end else if (reg_addr_from == SRC_ALU) begin
      wb_data_d = alu_res;
    end
  end

  assign out_hit = wb_valid_q && (wb_addr_q == OUT_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wb_valid_q  <= mov_enable;
      if (mov_enable) begin
        wb_addr_q <= reg_addr_to;
        wb_data_q <= wb_data_d;
      end
      out_valid_q <= out_hit;
      if (out_hit) begin
        out_data_q <= wb_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_valid_q) begin
      regs_q[wb_addr_q] <= wb_data_q;
    end
  end

`ifdef REG_TRANSFER_FLAGS_EN
  logic       wb_alu_q;
  logic [2:0] wb_flags_q;
  logic [2:0] flags_q;
  logic [2:0] flags_d;

  assign flags_d = {alu_res[DATA_W-1], (alu_res == '0), alu_wide[DATA_W]};

  // Flags travel with the move and commit only when an ALU move reaches writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_alu_q   <= 1'b0;
      wb_flags_q <= 3'b000;
      flags_q    <= 3'b000;
    end else begin
      if (mov_enable) begin
        wb_alu_q   <= (reg_addr_from == SRC_ALU);
        wb_flags_q <= flags_d;
      end
      if (wb_valid_q && wb_alu_q) begin
        flags_q <= wb_flags_q;
      end
    end
  end

  assign flags = flags_q;
`else
  logic unused_carry;
  assign unused_carry = alu_wide[DATA_W];
  assign flags        = 3'b000;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_reg_transfer_unit.sv
// Randomised bench for reg_transfer_unit against a sequential architectural model.
module tb_reg_transfer_unit;

`ifdef REG_TRANSFER_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mov_enable = 1'b0;
  logic [3:0]  reg_addr_from = 4'h0;
  logic [3:0]  reg_addr_to = 4'h0;
  logic [15:0] operand = 16'h0;
  logic [3:0]  dbg_addr = 4'h0;
  logic [15:0] out_data;
  logic        out_valid;
  logic [2:0]  flags;
  logic [15:0] dbg_data;

  reg_transfer_unit #(.DATA_W(16), .OUT_ADDR(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .mov_enable(mov_enable),
    .reg_addr_from(reg_addr_from), .reg_addr_to(reg_addr_to), .operand(operand),
    .out_data(out_data), .out_valid(out_valid), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // arch: every accepted move applied in order; comm: what the register file holds.
  logic [15:0] arch [16];
  logic [15:0] comm [16];
  logic [15:0] m_out = 16'h0;
  logic        m_outv = 1'b0;
  logic [2:0]  m_flags = 3'b000;
  bit          pend_out = 1'b0;
  logic [15:0] pend_out_data = 16'h0;
  bit          pend_flags_v = 1'b0;
  logic [2:0]  pend_flags = 3'b000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] ref_alu(input int op, input int a, input int b);
    int r;
    bit c;
    logic [15:0] res;
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 65535); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      default: r = a;
    endcase
    res = r[15:0];
    return {res[15], (res == 16'h0), c, res};
  endfunction

  task automatic model_edge(input bit rn, input bit en, input logic [3:0] from,
                            input logic [3:0] to, input logic [15:0] op);
    logic [15:0] v;
    logic [18:0] a;
    if (!rn) begin
      for (int i = 0; i < 16; i++) begin
        arch[i] = 16'h0;
        comm[i] = 16'h0;
      end
      m_out = 16'h0; m_outv = 1'b0; m_flags = 3'b000;
      pend_out = 1'b0; pend_flags_v = 1'b0;
    end else begin
      comm = arch;
      m_outv = pend_out;
      if (pend_out) m_out = pend_out_data;
      if (pend_flags_v) m_flags = pend_flags;
      pend_out = 1'b0;
      pend_flags_v = 1'b0;
      if (en) begin
        if (from == 4'hA) begin
          v = op;
        end else if (from == 4'hD) begin
          a = ref_alu(int'(op[3:0]), int'(arch[11]), int'(arch[12]));
          v = a[15:0];
          pend_flags_v = 1'b1;
          pend_flags = a[18:16];
        end else begin
          v = arch[from];
        end
        arch[to] = v;
        if (to == 4'hF) begin
          pend_out = 1'b1;
          pend_out_data = v;
        end
      end
    end
  endtask

  task automatic step(input bit rn, input bit en, input logic [3:0] from, input logic [3:0] to,
                      input logic [15:0] op, input logic [3:0] dbg);
    rst_n = rn; mov_enable = en; reg_addr_from = from; reg_addr_to = to; operand = op;
    @(posedge clk);
    model_edge(rn, en, from, to, op);
    $display("[TB] t=%0t rst_n=%0b en=%0b from=%h to=%h op=%h", $time, rn, en, from, to, op);
    #1;
    dbg_addr = dbg;
    #1;
    check("dbg_data", 32'(dbg_data), 32'(comm[dbg]));
    check("out_valid", 32'(out_valid), 32'(m_outv));
    check("out_data", 32'(out_data), 32'(m_out));
    check("flags", 32'(flags), FLAGS_EN ? 32'(m_flags) : 32'h0);
    mov_enable = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  function automatic logic [3:0] pick_addr();
    logic [3:0] hot [5];
    hot[0] = 4'hA; hot[1] = 4'hB; hot[2] = 4'hC; hot[3] = 4'hD; hot[4] = 4'hF;
    if ($urandom_range(0, 1) == 0) return hot[$urandom_range(0, 4)];
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [15:0] rop;
    step(0, 1, 4'hA, 4'h1, 16'h9999, 4'h1);
    step(0, 0, 4'h0, 4'h0, 16'h0, 4'h0);
    for (int i = 0; i < 16; i++) peek("reset_reg", 4'(i), 16'h0);

    step(1, 1, 4'hA, 4'h1, 16'h1234, 4'h1);
    peek("imm_not_yet", 4'h1, 16'h0);
    step(1, 0, 4'h0, 4'h0, 16'h0, 4'h1);
    peek("imm_load", 4'h1, 16'h1234);
    peek("imm_other", 4'h2, 16'h0);

    step(1, 1, 4'hA, 4'h1, 16'h00FF, 4'h0);
    step(1, 1, 4'h1, 4'h2, 16'h0, 4'h0);
    step(1, 0, 4'h0, 4'h0, 16'h0, 4'h2);
    peek("fwd_reg2", 4'h2, 16'h00FF);

    step(1, 1, 4'hA, 4'hB, 16'hFFFF, 4'h0);
    step(1, 1, 4'hA, 4'hC, 16'h0001, 4'h0);
    step(1, 1, 4'hD, 4'h3, 16'h0000, 4'h0);
    step(1, 0, 4'h0, 4'h0, 16'h0, 4'h3);
    peek("add_res", 4'h3, 16'h0000);
    check("add_flags", 32'(flags), FLAGS_EN ? 32'h3 : 32'h0);

    step(1, 1, 4'hA, 4'hB, 16'h0002, 4'h0);
    step(1, 1, 4'hA, 4'hC, 16'h0005, 4'h0);
    step(1, 1, 4'hD, 4'h4, 16'h0001, 4'h0);
    step(1, 0, 4'h0, 4'h0, 16'h0, 4'h4);
    peek("sub_res", 4'h4, 16'hFFFD);
    check("sub_flags", 32'(flags), FLAGS_EN ? 32'h5 : 32'h0);
    step(1, 1, 4'hA, 4'hC, 16'h0002, 4'h0);
    step(1, 1, 4'hD, 4'h5, 16'h0004, 4'h0);
    step(1, 0, 4'h0, 4'h0, 16'h0, 4'h5);
    peek("xor_res", 4'h5, 16'h0000);
    check("xor_flags", 32'(flags), FLAGS_EN ? 32'h2 : 32'h0);

    step(1, 1, 4'hA, 4'hF, 16'hAAAA, 4'h0);
    check("out_idle", 32'(out_valid), 32'h0);
    step(1, 1, 4'hA, 4'hF, 16'h5555, 4'h0);
    check("out_v1", 32'(out_valid), 32'h1);
    check("out_d1", 32'(out_data), 32'hAAAA);
    step(1, 0, 4'h0, 4'h0, 16'h0, 4'h0);
    check("out_v2", 32'(out_valid), 32'h1);
    check("out_d2", 32'(out_data), 32'h5555);
    step(1, 0, 4'h0, 4'h0, 16'h0, 4'h0);
    check("out_v3", 32'(out_valid), 32'h0);

    step(1, 1, 4'hA, 4'hF, 16'h1357, 4'h0);
    step(1, 1, 4'hA, 4'h4, 16'h7777, 4'h0);
    step(0, 1, 4'hA, 4'h6, 16'h4444, 4'h4);
    peek("rst_reg4", 4'h4, 16'h0);
    peek("rst_reg6", 4'h6, 16'h0);
    check("rst_outv", 32'(out_valid), 32'h0);
    check("rst_outd", 32'(out_data), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0: rop = 16'h0000;
        1: rop = 16'hFFFF;
        default: rop = 16'($urandom());
      endcase
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0),
           pick_addr(), pick_addr(), rop, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
